// File: rtl/pack_pkg.sv
// Shared types and helpers for the streaming lane packer.
// Helpers are sized for the widest supported lane count.
package pack_pkg;

    localparam int MAX_N = 128;

    typedef logic [$clog2(MAX_N):0] cnt_t;

    typedef enum logic {
        ACC,
        FLUSH_PEND
    } fsm_t;

    function automatic cnt_t popcnt(input logic [MAX_N-1:0] v);
        cnt_t c;
        c = '0;
        for (int i = 0; i < MAX_N; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [MAX_N-1:0] unary_mask(input cnt_t cnt);
        logic [MAX_N-1:0] m;
        for (int i = 0; i < MAX_N; i++) begin
            m[i] = (i < int'(cnt));
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_compact.sv
// Combinational lane compactor: valid lanes move down to
// the lowest slots while keeping their relative order.
module pack_compact
    import pack_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic [N*W-1:0]      in_w,
    input  logic [N-1:0]        lane_vld,
    output logic [N*W-1:0]      cmp_w,
    output logic [$clog2(N):0]  cmp_cnt
);

    localparam int CW = $clog2(N) + 1;

    int unsigned pos;

    assign cmp_cnt = CW'(popcnt(MAX_N'(lane_vld)));

    // The running count of valid lanes below lane i is its output slot.
    always_comb begin
        cmp_w = '0;
        pos = 0;
        for (int i = 0; i < N; i++) begin
            if (lane_vld[i]) begin
                cmp_w[pos*W +: W] = in_w[i*W +: W];
                pos = pos + 1;
            end
        end
    end

endmodule

// File: rtl/pack_stream.sv
// Streaming lane packer: merges compacted input lanes onto a
// residue buffer and emits dense beats through an output register.
module pack_stream
    import pack_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [N*W-1:0] in_w,
    input  logic [N-1:0]   in_lane_vld,
    input  logic           in_flush,
    output logic           out_vld_r,
    input  logic           out_rdy,
    output logic [N*W-1:0] out_r,
    output logic [N-1:0]   out_lane_vld_r,
    output logic           out_last_r
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] NC = CW'(N);

    fsm_t            state;
    logic [CW-1:0]   res_cnt;
    logic [W-1:0]    res [N-1];
    logic [N*W-1:0]  cmp_w;
    logic [CW-1:0]   cmp_cnt;
    logic [W-1:0]    comb_q [2*N];
    logic [CW-1:0]   total;
    logic            out_free;
    logic            accept;

    pack_compact #(
        .N(N),
        .W(W)
    ) u_compact (
        .in_w     (in_w),
        .lane_vld (in_lane_vld),
        .cmp_w    (cmp_w),
        .cmp_cnt  (cmp_cnt)
    );

    // total peaks at 2N-1, which fits CW bits exactly.
    assign total    = res_cnt + cmp_cnt;
    assign out_free = !out_vld_r || out_rdy;
    assign in_rdy   = rst_n && (state == ACC) && out_free;
    assign accept   = in_vld && in_rdy;

    always_comb begin
        for (int i = 0; i < 2*N; i++) begin
            comb_q[i] = '0;
        end
        for (int i = 0; i < N-1; i++) begin
            comb_q[i] = res[i];
        end
        for (int j = 0; j < N; j++) begin
            comb_q[res_cnt + CW'(j)] = cmp_w[j*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_vld_r      <= 1'b0;
            out_lane_vld_r <= '0;
            out_last_r     <= 1'b0;
            res_cnt        <= '0;
            state          <= ACC;
        end else if (out_free) begin
            out_vld_r <= 1'b0;
            unique case (state)
                ACC: begin
                    if (accept) begin
                        if (in_flush && total <= NC) begin
                            out_vld_r      <= 1'b1;
                            out_lane_vld_r <= N'(unary_mask(cnt_t'(total)));
                            out_last_r     <= 1'b1;
                            res_cnt        <= '0;
                            for (int i = 0; i < N; i++) begin
                                out_r[i*W +: W] <= comb_q[i];
                            end
                        end else if (total >= NC) begin
                            out_vld_r      <= 1'b1;
                            out_lane_vld_r <= '1;
                            out_last_r     <= 1'b0;
                            res_cnt        <= total - NC;
                            state          <= in_flush ? FLUSH_PEND : ACC;
                            for (int i = 0; i < N; i++) begin
                                out_r[i*W +: W] <= comb_q[i];
                            end
                            for (int i = 0; i < N-1; i++) begin
                                res[i] <= comb_q[N+i];
                            end
                        end else begin
                            res_cnt <= total;
                            for (int i = 0; i < N-1; i++) begin
                                res[i] <= comb_q[i];
                            end
                        end
                    end
                end
                FLUSH_PEND: begin
                    out_vld_r      <= 1'b1;
                    out_lane_vld_r <= N'(unary_mask(cnt_t'(res_cnt)));
                    out_last_r     <= 1'b1;
                    res_cnt        <= '0;
                    state          <= ACC;
                    for (int i = 0; i < N-1; i++) begin
                        out_r[i*W +: W] <= res[i];
                    end
                    out_r[(N-1)*W +: W] <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pack_stream.sv
// Bench for pack_stream: directed literal cases followed by random
// traffic checked against a queue-based model of the packer.
module tb_pack_stream;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [N*W-1:0] in_w = '0;
    logic [N-1:0]   in_lane_vld = '0;
    logic           in_flush = 1'b0;
    logic           out_vld_r;
    logic           out_rdy = 1'b1;
    logic [N*W-1:0] out_r;
    logic [N-1:0]   out_lane_vld_r;
    logic           out_last_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pack_stream #(
        .N(N),
        .W(W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_vld         (in_vld),
        .in_rdy         (in_rdy),
        .in_w           (in_w),
        .in_lane_vld    (in_lane_vld),
        .in_flush       (in_flush),
        .out_vld_r      (out_vld_r),
        .out_rdy        (out_rdy),
        .out_r          (out_r),
        .out_lane_vld_r (out_lane_vld_r),
        .out_last_r     (out_last_r)
    );

    typedef struct {
        logic [N*W-1:0] data;
        int             cnt;
        logic           last;
    } beat_t;

    beat_t        exp_q[$];
    logic [W-1:0] pend[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void emit(input int cnt, input logic last);
        beat_t b;
        b.data = '0;
        for (int i = 0; i < cnt; i++) begin
            b.data[i*W +: W] = pend.pop_front();
        end
        b.cnt  = cnt;
        b.last = last;
        exp_q.push_back(b);
    endfunction

    function automatic void model_accept(input logic [N*W-1:0] w,
                                         input logic [N-1:0] m,
                                         input logic f);
        for (int i = 0; i < N; i++) begin
            if (m[i]) pend.push_back(w[i*W +: W]);
        end
        if (f) begin
            while (pend.size() > N) emit(N, 1'b0);
            emit(pend.size(), 1'b1);
        end else begin
            while (pend.size() >= N) emit(N, 1'b0);
        end
    endfunction

    logic           rst_seen = 1'b0;
    logic           held = 1'b0;
    logic           must_vld = 1'b0;
    logic           free;
    logic [N*W-1:0] h_r;
    logic [N-1:0]   h_m;
    logic           h_l;
    logic [N-1:0]   msk;
    logic [N*W-1:0] wm;
    beat_t          cur;

    always @(negedge clk) begin
        if (!rst_n) begin
            if (rst_seen) begin
                chk("rst_out_vld", 64'(out_vld_r), 64'(0));
                chk("rst_in_rdy", 64'(in_rdy), 64'(0));
            end
            exp_q.delete();
            pend.delete();
            held = 1'b0;
            must_vld = 1'b0;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            if (held) begin
                chk("hold_vld", 64'(out_vld_r), 64'(1));
                chk("hold_data", 64'(out_r), 64'(h_r));
                chk("hold_mask", 64'(out_lane_vld_r), 64'(h_m));
                chk("hold_last", 64'(out_last_r), 64'(h_l));
            end
            if (must_vld) chk("latency", 64'(out_vld_r), 64'(1));
            if (out_vld_r) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got mask %0h want none",
                             out_lane_vld_r);
                end else begin
                    cur = exp_q[0];
                    msk = N'((1 << cur.cnt) - 1);
                    for (int i = 0; i < N; i++) begin
                        wm[i*W +: W] = {W{msk[i]}};
                    end
                    chk("out_mask", 64'(out_lane_vld_r), 64'(msk));
                    chk("out_last", 64'(out_last_r), 64'(cur.last));
                    chk("out_data", 64'(out_r & wm), 64'(cur.data));
                    if (out_rdy) void'(exp_q.pop_front());
                end
            end
            free = !out_vld_r || out_rdy;
            chk("in_rdy", 64'(in_rdy), 64'(free && exp_q.size() == 0));
            if (in_vld && in_rdy) model_accept(in_w, in_lane_vld, in_flush);
            held = out_vld_r && !out_rdy;
            h_r = out_r;
            h_m = out_lane_vld_r;
            h_l = out_last_r;
            must_vld = free && exp_q.size() > 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] m, input logic [N*W-1:0] w,
                         input logic f);
        in_vld = 1'b1;
        in_lane_vld = m;
        in_w = w;
        in_flush = f;
    endtask

    task automatic idle();
        in_vld = 1'b0;
        in_flush = 1'b0;
    endtask

    initial begin
        in_vld = 1'b1;
        step();
        step();
        chk("reset_out_vld", 64'(out_vld_r), 64'(0));
        chk("reset_in_rdy", 64'(in_rdy), 64'(0));
        rst_n = 1'b1;
        idle();
        step();
        chk("idle_in_rdy", 64'(in_rdy), 64'(1));
        chk("idle_res_cnt", 64'(dut.res_cnt), 64'(0));

        drive(4'b0101, {8'hEE, 8'h0C, 8'hEE, 8'h0A}, 1'b0);
        step();
        chk("acc_no_out", 64'(out_vld_r), 64'(0));
        drive(4'b0011, {8'hEE, 8'hEE, 8'h0F, 8'h0E}, 1'b0);
        step();
        chk("acc_vld", 64'(out_vld_r), 64'(1));
        chk("acc_data", 64'(out_r), 64'(32'h0F0E0C0A));
        chk("acc_mask", 64'(out_lane_vld_r), 64'(4'hF));
        chk("acc_last", 64'(out_last_r), 64'(0));
        chk("acc_res_cnt", 64'(dut.res_cnt), 64'(0));

        drive(4'b0111, {8'hEE, 8'h0C, 8'h0B, 8'h0A}, 1'b0);
        step();
        drive(4'b1111, {8'h10, 8'h0F, 8'h0E, 8'h0D}, 1'b0);
        step();
        chk("ovf_data", 64'(out_r), 64'(32'h0D0C0B0A));
        chk("ovf_res_cnt", 64'(dut.res_cnt), 64'(3));

        drive(4'b1110, {8'h13, 8'h12, 8'h11, 8'hEE}, 1'b1);
        step();
        idle();
        chk("fl1_data", 64'(out_r), 64'(32'h11100F0E));
        chk("fl1_last", 64'(out_last_r), 64'(0));
        chk("fl1_in_rdy", 64'(in_rdy), 64'(0));
        step();
        chk("fl2_data", 64'(out_r[15:0]), 64'(16'h1312));
        chk("fl2_mask", 64'(out_lane_vld_r), 64'(4'h3));
        chk("fl2_last", 64'(out_last_r), 64'(1));
        step();
        chk("fl_done_rdy", 64'(in_rdy), 64'(1));

        drive(4'b0000, {8'hEE, 8'hEE, 8'hEE, 8'hEE}, 1'b1);
        step();
        idle();
        chk("empty_vld", 64'(out_vld_r), 64'(1));
        chk("empty_mask", 64'(out_lane_vld_r), 64'(0));
        chk("empty_last", 64'(out_last_r), 64'(1));

        out_rdy = 1'b0;
        drive(4'b1111, {8'h24, 8'h23, 8'h22, 8'h21}, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_in_rdy", 64'(in_rdy), 64'(0));
            chk("bp_last", 64'(out_last_r), 64'(1));
        end
        out_rdy = 1'b1;
        step();
        idle();
        chk("bp_data", 64'(out_r), 64'(32'h24232221));
        chk("bp_mask", 64'(out_lane_vld_r), 64'(4'hF));
        step();

        drive(4'b0011, {8'hEE, 8'hEE, 8'h32, 8'h31}, 1'b0);
        step();
        idle();
        chk("mr_no_out", 64'(out_vld_r), 64'(0));
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("mr_res_cnt", 64'(dut.res_cnt), 64'(0));
        drive(4'b1111, {8'h44, 8'h43, 8'h42, 8'h41}, 1'b0);
        step();
        idle();
        chk("mr_data", 64'(out_r), 64'(32'h44434241));
        step();

        for (int c = 0; c < 4000; c++) begin
            in_vld = ($urandom_range(0, 3) != 0);
            in_lane_vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                in_w[i*W +: W] = W'($urandom);
            end
            in_flush = ($urandom_range(0, 7) == 0);
            out_rdy = ($urandom_range(0, 9) < 7);
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end

        idle();
        rst_n = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            step();
        end
        step();
        chk("drain", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pack_stream.md
Name: pack_stream

Overview:
- Streaming lane packer. Each accepted beat carries up to N valid lanes, which are compacted in lane order and appended to a residue buffer.
- Emits dense N-lane output beats through a valid/ready register stage, so output beats contain no gaps.
- `in_flush` closes a packet and forces out a partial final beat.
- Sits between sparse producers (issue/filter stages) and wide consumers.

Parameters:
- N, 8, lane count per beat (power of two, >=2)
- W, 32, lane data width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld & in_rdy
- in_w  in  N*W  input lane data; lane 0 is oldest
- in_lane_vld  in  N  per-lane valid mask; arbitrary sparsity
- in_flush  in  1  beat closes the packet
- out_vld_r  out  1  output beat valid
- out_rdy  in  1  downstream ready
- out_r  out  N*W  packed output data
- out_lane_vld_r  out  N  unary mask of valid output lanes
- out_last_r  out  1  final beat of packet

Behaviour:
- One clock `clk`. Reset `rst_n` is synchronous, active-low.
- Reset values:
  - out_vld_r=0, out_lane_vld_r=0, out_last_r=0
  - res_cnt=0, state=ACC
  - out_r and residue data are not reset; out_r is don't-care while out_vld_r=0.
- Reset asserted mid-packet discards the residue and any held output beat.
- Residue buffer: N-1 entries of W bits, plus res_cnt (0..N-1, width $clog2(N)+1).
- Compaction: K = popcount(in_lane_vld). Valid lanes keep ascending lane order.
  - combined = residue[0..res_cnt-1] followed by the compacted lanes.
  - total = res_cnt+K, range 0..2N-1.
- out_free = !out_vld_r | out_rdy.
- in_rdy = (state==ACC) & out_free.
  - in_rdy does not depend on in_vld.
  - While out_vld_r=1 and out_rdy=0, all out_* hold stable.
- Latency: an accepted beat that produces output is visible on out_* in the next cycle.
- FSM states: ACC, FLUSH_PEND.
- ACC, accept with in_flush=0:
  - total<N: append; res_cnt=total; no output.
  - total>=N: out_r=combined[0..N-1], mask all-ones, last=0. Residue = combined[N..total-1]; res_cnt=total-N.
- ACC, accept with in_flush=1:
  - total<=N: emit combined[0..total-1]; mask=~('1<<total); last=1; res_cnt=0.
  - total==0: emits mask=0, last=1. This empty terminator beat is intentional.
  - total>N: emit full beat, last=0. Residue = combined[N..total-1]. Go to FLUSH_PEND.
- FLUSH_PEND:
  - in_rdy=0.
  - When out_free: emit residue with mask=~('1<<res_cnt), last=1. Set res_cnt=0; go to ACC.
- No accept in a cycle where out_free=1: out_vld_r clears to 0.
- Input with in_vld=0 is ignored. in_lane_vld and in_flush are ignored when not accepted.
- Output mask is always unary from lane 0.
- Lanes of out_r beyond the mask are don't-care.

Decomposition:
- Package pack_pkg:
  - cnt_t = logic [$clog2(N):0]
  - fsm_t enum {ACC, FLUSH_PEND}
  - function popcnt
  - function unary_mask(cnt)
- Sub-module pack_compact #(N,W):
  - purely combinational prefix-popcount crossbar
  - outputs compacted data and K
  - reused for compaction of in_w
- Top module holds the residue shifter/merge, FSM and output register.

Test Plan (N=4, W=8):
- Reset then idle: rst_n=0 for 2 cycles with in_vld=1 → out_vld_r=0, in_rdy=0 during reset. After release, in_rdy=1, res_cnt=0.
- Accumulate: beats with masks 0101 (A,C), then 0011 (E,F), out_rdy=1 → no output after beat 1. After beat 2: out_r={F,E,C,A} (lane3..0), mask=1111, last=0, res_cnt=0.
- Overflow residue: masks 0111 (A,B,C) then 1111 (D,E,F,G) → beat {D,C,B,A} mask 1111; residue {G,F,E}, res_cnt=3.
- Flush two-beat: residue 3 entries, then beat mask 1110 (H,I,J) with flush →
  - cycle1: {H,G,F,E} mask 1111, last=0, in_rdy=0 (FLUSH_PEND)
  - cycle2: {J,I} mask 0011, last=1
  - then in_rdy=1.
- Backpressure: out_rdy=0 for 5 cycles with output pending → out_* stable, in_rdy=0. After out_rdy=1, the next accepted beat appears one cycle later; no data lost or duplicated.
- Empty flush: res_cnt=0, beat mask 0000 with flush=1 → out_vld_r=1, mask 0000, last=1. Mid-packet rst_n=0 → residue discarded; next packet begins at lane 0.
